// File: rtl/s_array_ksa_pkg.sv
// Shared types and defaults for the RC4 S-array engine (init fill + optional KSA, see S_ARRAY_KSA_EN).
package s_array_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_KEY_BYTES = 3;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT_WR = 4'd1,
    ST_RD_I    = 4'd2,
    ST_GET_I   = 4'd3,
    ST_RD_J    = 4'd4,
    ST_GET_J   = 4'd5,
    ST_WR_I    = 4'd6,
    ST_WR_J    = 4'd7,
    ST_DONE    = 4'd8
  } state_e;

  typedef enum logic {
    MODE_INIT = 1'b0,
    MODE_KSA  = 1'b1
  } mode_e;

endpackage

// File: rtl/s_array_ksa_if.sv
// Control handshake and single-port S RAM bus of the S-array engine.
interface s_array_ksa_if #(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3
);
  logic                          start;
  logic                          mode;
  logic [KEY_BYTES*DATA_W-1:0]   key;
  logic [DATA_W-1:0]             s_address;
  logic [DATA_W-1:0]             s_data;
  logic                          s_wren;
  logic [DATA_W-1:0]             s_q;
  logic                          busy;
  logic                          done;

  modport master (
    input  start, mode, key, s_q,
    output s_address, s_data, s_wren, busy, done
  );

  modport slave (
    output start, mode, key, s_q,
    input  s_address, s_data, s_wren, busy, done
  );
endinterface

// File: rtl/s_array_ksa_key_byte_sel.sv
// Picks key byte k out of a packed key whose byte 0 is the most-significant byte.
module key_byte_sel #(
  parameter int DATA_W    = 8,
  parameter int KEY_BYTES = 3,
  parameter int K_W       = 2
) (
  input  logic [KEY_BYTES*DATA_W-1:0] key,
  input  logic [K_W-1:0]              k,
  output logic [DATA_W-1:0]           key_byte
);

  // byte mux, MSB-first
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k == K_W'(b)) begin
        key_byte = key[(KEY_BYTES-1-b)*DATA_W +: DATA_W];
      end else begin
        key_byte = key_byte;
      end
    end
  end

endmodule

// File: rtl/s_array_ksa.sv
// RC4 S-array engine: identity fill, then (with S_ARRAY_KSA_EN defined) the KSA swap loop.
module s_array_ksa
  import s_array_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int KEY_BYTES = DEF_KEY_BYTES
) (
  input  logic          clk,
  input  logic          reset_n,
  s_array_ksa_if.master bus
);

  localparam int K_W = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [DATA_W-1:0] I_MAX = {DATA_W{1'b1}};

  localparam logic [3:0] IDLE    = ST_IDLE;
  localparam logic [3:0] INIT_WR = ST_INIT_WR;
  localparam logic [3:0] DONE    = ST_DONE;
`ifdef S_ARRAY_KSA_EN
  localparam logic [3:0] RD_I    = ST_RD_I;
  localparam logic [3:0] GET_I   = ST_GET_I;
  localparam logic [3:0] RD_J    = ST_RD_J;
  localparam logic [3:0] GET_J   = ST_GET_J;
  localparam logic [3:0] WR_I    = ST_WR_I;
  localparam logic [3:0] WR_J    = ST_WR_J;
  localparam logic [K_W-1:0] K_LAST = K_W'(KEY_BYTES-1);
`endif

  logic [3:0]        state_q, state_d;
  logic [DATA_W-1:0] i_q, i_d;
  logic [DATA_W-1:0] s_address_q, s_address_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;
  logic              s_wren_q, s_wren_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DATA_W-1:0] key_byte_s;
  logic [K_W-1:0]    k_sel_s;
  logic [KEY_BYTES*DATA_W-1:0] key_sel_s;

`ifdef S_ARRAY_KSA_EN
  logic                        mode_q, mode_d;
  logic [KEY_BYTES*DATA_W-1:0] key_q, key_d;
  logic [DATA_W-1:0]           j_q, j_d;
  logic [DATA_W-1:0]           si_q, si_d;
  logic [DATA_W-1:0]           sj_q, sj_d;
  logic [K_W-1:0]              k_q, k_d;

  assign k_sel_s   = k_q;
  assign key_sel_s = key_q;
`else
  logic unused_s;

  assign k_sel_s   = '0;
  assign key_sel_s = bus.key;
  assign unused_s  = ^{bus.mode, bus.s_q, key_byte_s};
`endif

  key_byte_sel #(
    .DATA_W   (DATA_W),
    .KEY_BYTES(KEY_BYTES),
    .K_W      (K_W)
  ) u_key_byte_sel (
    .key     (key_sel_s),
    .k       (k_sel_s),
    .key_byte(key_byte_s)
  );

  // next state and index/key/swap registers
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
`ifdef S_ARRAY_KSA_EN
    mode_d  = mode_q;
    key_d   = key_q;
    j_d     = j_q;
    si_d    = si_q;
    sj_d    = sj_q;
    k_d     = k_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = INIT_WR;
          i_d     = '0;
`ifdef S_ARRAY_KSA_EN
          mode_d  = bus.mode;
          key_d   = bus.key;
          j_d     = '0;
          k_d     = '0;
`endif
        end else begin
          state_d = state_q;
        end
      end
      INIT_WR: begin
        if (i_q == I_MAX) begin
          i_d = '0;
`ifdef S_ARRAY_KSA_EN
          state_d = (mode_q == MODE_KSA) ? RD_I : DONE;
`else
          state_d = DONE;
`endif
        end else begin
          i_d = i_q + {{(DATA_W-1){1'b0}}, 1'b1};
        end
      end
`ifdef S_ARRAY_KSA_EN
      RD_I:  state_d = GET_I;
      GET_I: begin
        si_d    = bus.s_q;
        j_d     = j_q + bus.s_q + key_byte_s;
        k_d     = (k_q == K_LAST) ? '0 : k_q + {{(K_W-1){1'b0}}, 1'b1};
        state_d = RD_J;
      end
      RD_J:  state_d = GET_J;
      GET_J: begin
        sj_d    = bus.s_q;
        state_d = WR_I;
      end
      WR_I:  state_d = WR_J;
      WR_J: begin
        if (i_q == I_MAX) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + {{(DATA_W-1){1'b0}}, 1'b1};
          state_d = RD_I;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // RAM/status outputs decoded from the next state so they appear registered
  always_comb begin
    s_address_d = s_address_q;
    s_data_d    = s_data_q;
    s_wren_d    = 1'b0;
    busy_d      = (state_d != IDLE) && (state_d != DONE);
    done_d      = (state_d == DONE);
    case (state_d)
      INIT_WR: begin
        s_address_d = i_d;
        s_data_d    = i_d;
        s_wren_d    = 1'b1;
      end
`ifdef S_ARRAY_KSA_EN
      RD_I: s_address_d = i_d;
      RD_J: s_address_d = j_d;
      WR_I: begin
        s_address_d = i_d;
        s_data_d    = sj_d;
        s_wren_d    = 1'b1;
      end
      WR_J: begin
        s_address_d = j_d;
        s_data_d    = si_d;
        s_wren_d    = 1'b1;
      end
`endif
      default: s_wren_d = 1'b0;
    endcase
  end

  // state, counters and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      s_address_q <= '0;
      s_data_q    <= '0;
      s_wren_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef S_ARRAY_KSA_EN
      mode_q      <= 1'b0;
      key_q       <= '0;
      j_q         <= '0;
      si_q        <= '0;
      sj_q        <= '0;
      k_q         <= '0;
`endif
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      s_address_q <= s_address_d;
      s_data_q    <= s_data_d;
      s_wren_q    <= s_wren_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef S_ARRAY_KSA_EN
      mode_q      <= mode_d;
      key_q       <= key_d;
      j_q         <= j_d;
      si_q        <= si_d;
      sj_q        <= sj_d;
      k_q         <= k_d;
`endif
    end
  end

  assign bus.s_address = s_address_q;
  assign bus.s_data    = s_data_q;
  assign bus.s_wren    = s_wren_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_s_array_ksa.sv
// Randomized bench for s_array_ksa against a software RC4 KSA model and a behavioural synchronous RAM.
`timescale 1ns/1ps
module tb_s_array_ksa;

  localparam int DW = 8;
  localparam int KB = 3;
  localparam int N  = 256;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  s_array_ksa_if #(.DATA_W(DW), .KEY_BYTES(KB)) bus ();

  s_array_ksa #(.DATA_W(DW), .KEY_BYTES(KB)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // behavioural single-port RAM: write-first not assumed, read data one cycle later
  logic [7:0] mem [N];
  logic [7:0] q_r = 8'h00;
  always @(posedge clk) begin
    if (bus.s_wren) mem[bus.s_address] <= bus.s_data;
    q_r <= mem[bus.s_address];
  end
  assign bus.s_q = q_r;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, c, act, exp);
    end
  endtask

  // expected per-cycle bus activity, derived straight from the RC4 algorithm
  typedef struct {
    bit       wr;
    bit       ca;
    bit [7:0] a;
    bit [7:0] d;
  } ev_t;

  ev_t      tr[$];
  bit [7:0] ms [N];

  function automatic void ksa_model(input bit [23:0] k, input bit do_ksa);
    int j;
    bit [7:0] t;
    bit [7:0] kb;
    tr.delete();
    for (int n = 0; n < N; n++) begin
      ms[n] = 8'(n);
      tr.push_back('{1'b1, 1'b1, 8'(n), 8'(n)});
    end
    if (do_ksa) begin
      j = 0;
      for (int i = 0; i < N; i++) begin
        kb = k[8*(2-(i%3)) +: 8];
        j  = (j + int'(ms[i]) + int'(kb)) % N;
        tr.push_back('{1'b0, 1'b1, 8'(i), 8'h00});
        tr.push_back('{1'b0, 1'b0, 8'h00, 8'h00});
        tr.push_back('{1'b0, 1'b1, 8'(j), 8'h00});
        tr.push_back('{1'b0, 1'b0, 8'h00, 8'h00});
        tr.push_back('{1'b1, 1'b1, 8'(i), ms[j]});
        tr.push_back('{1'b1, 1'b1, 8'(j), ms[i]});
        t     = ms[i];
        ms[i] = ms[j];
        ms[j] = t;
      end
    end
  endfunction

  // pins the model to known RC4 facts (key "Key" keystream, trace lengths, early j values)
  task automatic pin_model();
    bit [7:0] p [N];
    bit [7:0] ks_exp [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
    bit [7:0] t;
    int pi, pj;
    ksa_model(24'h4B6579, 1'b1);
    chk("model_ksa_len", 0, tr.size(), 32'd1792);
    for (int n = 0; n < N; n++) p[n] = ms[n];
    pi = 0;
    pj = 0;
    for (int n = 0; n < 10; n++) begin
      pi = (pi + 1) % N;
      pj = (pj + int'(p[pi])) % N;
      t = p[pi]; p[pi] = p[pj]; p[pj] = t;
      chk("model_keystream", n, p[(int'(p[pi]) + int'(p[pj])) % N], ks_exp[n]);
    end
    ksa_model(24'h000000, 1'b1);
    chk("model_j_i0", 0, tr[256+2].a, 32'h00);
    chk("model_j_i1", 1, tr[256+8].a, 32'h01);
    chk("model_j_i2", 2, tr[256+14].a, 32'h03);
    ksa_model(24'h123456, 1'b0);
    chk("model_init_len", 0, tr.size(), 32'd256);
    chk("model_init_s", 0, ms[8'h5A], 32'h5A);
  endtask

  task automatic chk_zero_outputs(input string nm, input int c);
    chk({nm, "_addr"}, c, bus.s_address, 32'h0);
    chk({nm, "_data"}, c, bus.s_data, 32'h0);
    chk({nm, "_wren"}, c, bus.s_wren, 32'h0);
    chk({nm, "_busy"}, c, bus.busy, 32'h0);
    chk({nm, "_done"}, c, bus.done, 32'h0);
  endtask

  // one run from acceptance to done, checking the bus every cycle
  task automatic run(input bit m, input bit [23:0] k, input bit disturb, input int abort_at);
    bit  eff;
    int  done_c;
    int  ab;
    ev_t e;
`ifdef S_ARRAY_KSA_EN
    eff = m;
`else
    eff = 1'b0;
`endif
    ksa_model(k, eff);
    done_c = tr.size() + 1;
    ab = (abort_at >= done_c) ? done_c / 2 : abort_at;
    @(negedge clk);
    bus.mode  = m;
    bus.key   = k;
    bus.start = 1'b1;
    for (int c = 1; c <= done_c + 2; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (disturb && c == 100) begin
        bus.start = 1'b1;
        bus.key   = 24'($urandom);
        bus.mode  = ~m;
      end
      if (disturb && c == 101) bus.start = 1'b0;
      if (c == ab) begin
        #1 reset_n = 1'b0;
        #1;
        chk_zero_outputs("abort_reset", c);
        @(negedge clk);
        reset_n = 1'b1;
        return;
      end
      if (c < done_c) begin
        e = tr[c-1];
        chk("busy", c, bus.busy, 32'h1);
        chk("done", c, bus.done, 32'h0);
        chk("wren", c, bus.s_wren, e.wr);
        if (e.ca) chk("addr", c, bus.s_address, e.a);
        if (e.wr) chk("wdata", c, bus.s_data, e.d);
      end else begin
        chk("busy_end", c, bus.busy, 32'h0);
        chk("done_end", c, bus.done, 32'h1);
        chk("wren_end", c, bus.s_wren, 32'h0);
      end
    end
    for (int n = 0; n < N; n++) chk("final_s", n, mem[n], ms[n]);
  endtask

  initial begin
    bit [23:0] rk;
    for (int n = 0; n < N; n++) mem[n] = 8'h00;
    bus.start = 1'b0;
    bus.mode  = 1'b0;
    bus.key   = 24'h000000;
    reset_n   = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset", 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk_zero_outputs("idle", 0);

    pin_model();

    run(1'b0, 24'($urandom), 1'b0, 0);
    run(1'b1, 24'h000249, 1'b0, 0);
    run(1'b1, 24'h000000, 1'b0, 0);
    rk = 24'($urandom);
    run(1'b1, rk, 1'b1, 0);
    run(1'b1, rk, 1'b0, 0);
    run(1'b1, 24'($urandom), 1'b0, 500);
    @(negedge clk);
    chk_zero_outputs("after_abort", 0);
    run(1'b1, 24'h000249, 1'b0, 0);
    run(1'b0, 24'($urandom), 1'b0, 0);
    run(1'b1, 24'($urandom), 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/s_array_ksa.md
# s_array_ksa

Parametrised RC4 state-array engine: fills the S working memory with the identity permutation and, in KSA mode, runs the full key-scheduling swap loop over it. It drives the single-port S RAM directly (write and read) and reports completion with busy/done flags. It is the successor of the init-only S-array filler and sits between the top-level control FSM and the S memory, ahead of the PRGA/decrypt stage.

## Interface
- DATA_W, 8: S entry width; S depth is 2**DATA_W; all index arithmetic is mod 2**DATA_W
- KEY_BYTES, 3: secret key length in DATA_W-bit bytes
- clk  in  1  single clock; everything is posedge clk
- reset_n  in  1  one clock; reset is asynchronous and active-low
- start  in  1  request; sampled only in IDLE
- mode  in  1  0 = identity init only, 1 = init + KSA; latched when start is accepted
- key  in  KEY_BYTES*DATA_W  secret key; byte 0 = most-significant byte; latched when start is accepted
- s_address  out  DATA_W  S RAM address
- s_data  out  DATA_W  S RAM write data
- s_wren  out  1  S RAM write enable
- s_q  in  DATA_W  S RAM read data; synchronous RAM, valid the cycle after the address is presented
- busy  out  1  high from the cycle after start is accepted until done rises
- done  out  1  level; high in DONE, cleared when the next start is accepted

## Operation
- States: IDLE, INIT_WR, RD_I, GET_I, RD_J, GET_J, WR_I, WR_J, DONE.
- IDLE: start=1 -> latch mode/key, clear i, j and key index k to 0, go to INIT_WR.
- INIT_WR: s_address=i, s_data=i, s_wren=1, one entry per cycle. i==2**DATA_W-1 -> i<=0, go to RD_I if mode=1, otherwise DONE; else i++.
- RD_I: s_address=i, read.
- GET_I: si<=s_q; j<=j+s_q+key[k]; k wraps to 0 after KEY_BYTES-1 (wrap counter, no divider).
- RD_J: s_address=j, read. GET_J: sj<=s_q.
- WR_I: s_address=i, s_data=sj, s_wren=1. WR_J: s_address=j, s_data=si, s_wren=1.
- After WR_J: i==2**DATA_W-1 -> DONE, else i++, go to RD_I.
- When i==j, both writes store the original S[i]; the array is unchanged, which is correct. Read-during-write RAM behaviour is never relied on.
- DONE: hold done=1, busy=0, s_wren=0. start=1 -> accepted exactly as from IDLE.
- start while busy is ignored. key/mode changes after acceptance have no effect.
- s_wren is 0 in every state except INIT_WR, WR_I and WR_J.

## Timing
- Reset (async assert): state IDLE; s_address, s_data, s_wren, busy, done, i, j, k all 0. RAM contents are left partial and undefined.
- All outputs are registered off state/counters. start accepted at edge 0 -> first write (address 0) in cycle 1.
- Init: 2**DATA_W cycles. For mode=0, done=1 at cycle 2**DATA_W+1 (257 for DATA_W=8).
- KSA: 6 cycles per i, 6*2**DATA_W total. For mode=1, done=1 at cycle 7*2**DATA_W+1 (1793 for DATA_W=8).
- A second start in DONE restarts from INIT_WR on the next cycle; done drops in that same cycle.

## Configuration
- S_ARRAY_KSA_EN defined: full behaviour above.
- Not defined: RD_I..WR_J and the si/sj/j/k registers are not compiled in. mode is ignored and treated as 0; every run is init only; key is unused.

## Structure
- Package s_array_pkg: state enum, mode enum (MODE_INIT, MODE_KSA), default DATA_W/KEY_BYTES constants.
- One sub-module, key_byte_sel: combinational selection of key byte k from the latched key, MSB-first.

## Test plan
- Reset then start with mode=0, DATA_W=8 -> 256 writes S[n]=n on consecutive cycles; done=1 at cycle 257; no reads issued.
- mode=1, key=24'h000249, against a behavioural RAM -> final S matches the software RC4 KSA golden model byte-for-byte; done at cycle 1793.
- Check the i==j swap: key chosen so that some iteration has j==i (e.g. key all 0x00 at i=0, where j=0) -> S still a permutation matching the model.
- Pulse start at cycle 100 of a run, and change key/mode mid-run -> ignored, result identical to an undisturbed run.
- Assert reset_n low at cycle 500 of KSA -> outputs 0 immediately, busy=0, done=0; a new start completes a correct run.
- Build without S_ARRAY_KSA_EN and set mode=1 -> identity array only; done at cycle 257.
